// File: rtl/fir_pkg.sv
// Shared types for the FIR coefficient controller: word width, coefficient type
// and the configuration-load state encoding.
package fir_pkg;

  localparam int COEFF_W = 32;

  typedef logic signed [COEFF_W-1:0] coeff_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PEND = 2'd2
  } cfg_state_t;

endpackage

// File: rtl/fir_coeff_bank.sv
// Double coefficient bank: writes land in the shadow bank, a toggle makes the
// shadow bank active. coeffs always reflects the active bank.
module fir_coeff_bank
  import fir_pkg::*;
#(
  parameter int N       = 100,
  parameter int COEFF_W = 32,
  parameter int AW      = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [AW-1:0]      addr,
  input  logic [COEFF_W-1:0] data,
  input  logic               toggle,
  output logic [COEFF_W-1:0] coeffs [N-1:0]
);

  logic [COEFF_W-1:0] bank0_r [N-1:0];
  logic [COEFF_W-1:0] bank1_r [N-1:0];
  logic               sel_r;

  // bank storage, active-bank select and shadow write port
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_r <= 1'b0;
      for (int i = 0; i < N; i++) begin
        bank0_r[i] <= {COEFF_W{1'b0}};
        bank1_r[i] <= {COEFF_W{1'b0}};
      end
    end else begin
      if (toggle) begin
        sel_r <= ~sel_r;
      end
      // the shadow is the bank not currently selected
      if (we) begin
        if (sel_r) begin
          bank0_r[addr] <= data;
        end else begin
          bank1_r[addr] <= data;
        end
      end
    end
  end

  // active bank mux
  always_comb begin
    for (int i = 0; i < N; i++) begin
      coeffs[i] = sel_r ? bank1_r[i] : bank0_r[i];
    end
  end

endmodule

// File: rtl/fir_coeff_ctrl.sv
// FIR coefficient controller: serial shadow-bank load, gap-aligned bank swap and
// one-cycle sample stage. Optional cfg_abort input under `define FIR_CFG_ABORT_EN.
module fir_coeff_ctrl #(
  parameter int N       = 100,
  parameter int COEFF_W = 32,
  parameter int GEN_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [COEFF_W-1:0] cfg_data,
  input  logic               cfg_last,
`ifdef FIR_CFG_ABORT_EN
  input  logic               cfg_abort,
`endif
  input  logic               s_valid,
  input  logic [COEFF_W-1:0] s_data,
  output logic               f_valid,
  output logic [COEFF_W-1:0] f_x,
  output logic [COEFF_W-1:0] coeffs [N-1:0],
  output logic               swap_done,
  output logic               load_err,
  output logic [GEN_W-1:0]   coeff_gen
);
  import fir_pkg::*;

  localparam int            AW       = (N > 1) ? $clog2(N) : 1;
  localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

  cfg_state_t         state_r, state_s;
  logic [AW-1:0]      cnt_r, cnt_s;
  logic               cfg_ready_r;
  logic               f_valid_r;
  logic [COEFF_W-1:0] f_x_r;
  logic               swap_r, swap_s;
  logic               err_r, err_s;
  logic [GEN_W-1:0]   gen_r, gen_s;
  logic               we_s, toggle_s, xfer_s, abort_s;
  logic [AW-1:0]      waddr_s;

`ifdef FIR_CFG_ABORT_EN
  assign abort_s = cfg_abort;
`else
  assign abort_s = 1'b0;
`endif

  assign xfer_s = cfg_valid && cfg_ready_r;

  // next-state, shadow write and swap decisions
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    we_s     = 1'b0;
    waddr_s  = cnt_r;
    toggle_s = 1'b0;
    swap_s   = 1'b0;
    err_s    = 1'b0;
    gen_s    = gen_r;
    case (state_r)
      IDLE: begin
        if (xfer_s) begin
          we_s    = 1'b1;
          waddr_s = AW'(0);
          cnt_s   = AW'(1);
          // a one-word set can never be complete
          if (cfg_last) begin
            err_s = 1'b1;
          end else begin
            state_s = LOAD;
          end
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: begin
        if (abort_s) begin
          state_s = IDLE;
        end else if (xfer_s) begin
          we_s  = 1'b1;
          cnt_s = cnt_r + AW'(1);
          if (cnt_r == LAST_IDX) begin
            if (cfg_last) begin
              state_s = PEND;
            end else begin
              err_s   = 1'b1;
              state_s = IDLE;
            end
          end else if (cfg_last) begin
            err_s   = 1'b1;
            state_s = IDLE;
          end else begin
            state_s = LOAD;
          end
        end else begin
          state_s = LOAD;
        end
      end
      PEND: begin
        if (abort_s) begin
          state_s = IDLE;
        end else if (!s_valid) begin
          toggle_s = 1'b1;
          swap_s   = 1'b1;
          gen_s    = gen_r + GEN_W'(1);
          state_s  = IDLE;
        end else begin
          state_s = PEND;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // state, status pulses and sample stage registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= AW'(0);
      cfg_ready_r <= 1'b1;
      f_valid_r   <= 1'b0;
      f_x_r       <= {COEFF_W{1'b0}};
      swap_r      <= 1'b0;
      err_r       <= 1'b0;
      gen_r       <= GEN_W'(0);
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      cfg_ready_r <= (state_s != PEND);
      f_valid_r   <= s_valid;
      f_x_r       <= s_valid ? s_data : {COEFF_W{1'b0}};
      swap_r      <= swap_s;
      err_r       <= err_s;
      gen_r       <= gen_s;
    end
  end

  fir_coeff_bank #(
    .N       (N),
    .COEFF_W (COEFF_W),
    .AW      (AW)
  ) u_bank (
    .clk    (clk),
    .rst    (rst),
    .we     (we_s),
    .addr   (waddr_s),
    .data   (cfg_data),
    .toggle (toggle_s),
    .coeffs (coeffs)
  );

  assign cfg_ready = cfg_ready_r;
  assign f_valid   = f_valid_r;
  assign f_x       = f_x_r;
  assign swap_done = swap_r;
  assign load_err  = err_r;
  assign coeff_gen = gen_r;

endmodule

// File: tb/tb_fir_coeff_ctrl.sv
// Self-checking bench for fir_coeff_ctrl (N=4): directed scenarios plus random
// traffic, compared every cycle against a queue-based reference model.
module tb_fir_coeff_ctrl;

  localparam int N = 4;
  localparam int W = 32;
  localparam int G = 8;

  logic         clk = 1'b0;
  logic         rst, cfg_valid, cfg_last, s_valid;
  logic [W-1:0] cfg_data, s_data;
  logic         cfg_ready, f_valid, swap_done, load_err;
  logic [W-1:0] f_x;
  logic [W-1:0] coeffs [N-1:0];
  logic [G-1:0] coeff_gen;
`ifdef FIR_CFG_ABORT_EN
  logic         cfg_abort;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [W-1:0] m_act  [N];
  logic [W-1:0] m_pset [N];
  logic [W-1:0] m_words[$];
  bit           m_pend;
  logic [G-1:0] m_gen;
  bit           e_ready, e_fv, e_swap, e_err;
  logic [W-1:0] e_fx;

  always #5 clk = ~clk;

  fir_coeff_ctrl #(.N(N), .COEFF_W(W), .GEN_W(G)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_data  (cfg_data),
    .cfg_last  (cfg_last),
`ifdef FIR_CFG_ABORT_EN
    .cfg_abort (cfg_abort),
`endif
    .s_valid   (s_valid),
    .s_data    (s_data),
    .f_valid   (f_valid),
    .f_x       (f_x),
    .coeffs    (coeffs),
    .swap_done (swap_done),
    .load_err  (load_err),
    .coeff_gen (coeff_gen)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Apply the rules to the inputs present before the coming edge.
  task automatic model_step();
    bit ab;
    ab = 1'b0;
`ifdef FIR_CFG_ABORT_EN
    ab = cfg_abort;
`endif
    if (rst) begin
      for (int i = 0; i < N; i++) m_act[i] = '0;
      m_words.delete();
      m_pend  = 1'b0;
      m_gen   = '0;
      e_ready = 1'b1; e_fv = 1'b0; e_fx = '0; e_swap = 1'b0; e_err = 1'b0;
    end else begin
      e_fv   = s_valid;
      e_fx   = s_valid ? s_data : '0;
      e_swap = 1'b0;
      e_err  = 1'b0;
      if (ab && (m_pend || m_words.size() != 0)) begin
        m_pend = 1'b0;
        m_words.delete();
      end else if (m_pend) begin
        if (!s_valid) begin
          m_act  = m_pset;
          m_gen  = m_gen + 8'd1;
          e_swap = 1'b1;
          m_pend = 1'b0;
        end
      end else if (cfg_valid) begin
        m_words.push_back(cfg_data);
        if (cfg_last) begin
          if (m_words.size() == N) begin
            m_pend = 1'b1;
            for (int i = 0; i < N; i++) m_pset[i] = m_words[i];
          end else begin
            e_err = 1'b1;
          end
          m_words.delete();
        end else if (m_words.size() == N) begin
          e_err = 1'b1;
          m_words.delete();
        end
      end
      e_ready = !m_pend;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("cfg_ready", 64'(cfg_ready), 64'(e_ready));
    check("f_valid",   64'(f_valid),   64'(e_fv));
    check("f_x",       64'(f_x),       64'(e_fx));
    check("swap_done", 64'(swap_done), 64'(e_swap));
    check("load_err",  64'(load_err),  64'(e_err));
    check("coeff_gen", 64'(coeff_gen), 64'(m_gen));
    for (int i = 0; i < N; i++) check($sformatf("coeffs[%0d]", i), 64'(coeffs[i]), 64'(m_act[i]));
  endtask

  task automatic drive(input bit cv, input bit cl, input logic [W-1:0] cd,
                       input bit sv, input logic [W-1:0] sd);
    cfg_valid = cv; cfg_last = cl; cfg_data = cd; s_valid = sv; s_data = sd;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic load4(input logic [W-1:0] a, b, c, d, input bit sv);
    drive(1'b1, 1'b0, a, sv, $urandom);
    drive(1'b1, 1'b0, b, sv, $urandom);
    drive(1'b1, 1'b0, c, sv, $urandom);
    drive(1'b1, 1'b1, d, sv, $urandom);
  endtask

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; cfg_last = 1'b0; cfg_data = '0;
    s_valid = 1'b0; s_data = '0;
`ifdef FIR_CFG_ABORT_EN
    cfg_abort = 1'b0;
`endif
    tick(); tick();
    rst = 1'b0;

    // sample path
    drive(1'b0, 1'b0, '0, 1'b1, 32'd5);
    drive(1'b0, 1'b0, '0, 1'b1, 32'd6);
    drive(1'b0, 1'b0, '0, 1'b1, 32'd7);
    idle(2);

    // clean load with an immediate gap
    load4(32'd10, 32'd20, 32'd30, 32'd40, 1'b0);
    idle(3);

    // load during a continuous stream; words offered in PEND must be ignored
    load4(32'd1, 32'd2, 32'd3, 32'd4, 1'b1);
    for (int i = 0; i < 20; i++) drive(i < 5, 1'b0, 32'd99, 1'b1, $urandom);
    idle(3);

    // early cfg_last on word index 1
    drive(1'b1, 1'b0, 32'd7, 1'b0, '0);
    drive(1'b1, 1'b1, 32'd8, 1'b0, '0);
    idle(2);

    // cfg_last on the very first word
    drive(1'b1, 1'b1, 32'd9, 1'b0, '0);
    idle(1);

    // missing cfg_last on word index 3
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 32'(100 + i), 1'b0, '0);
    idle(2);

    // reset while a set is pending, then a full load
    load4(32'd51, 32'd52, 32'd53, 32'd54, 1'b1);
    drive(1'b0, 1'b0, '0, 1'b1, 32'd3);
    rst = 1'b1; drive(1'b0, 1'b0, '0, 1'b0, '0);
    rst = 1'b0; idle(2);
    load4(32'd11, 32'd12, 32'd13, 32'd14, 1'b0);
    idle(2);

`ifdef FIR_CFG_ABORT_EN
    // abort after two words, then a clean load
    drive(1'b1, 1'b0, 32'd61, 1'b0, '0);
    drive(1'b1, 1'b0, 32'd62, 1'b0, '0);
    cfg_abort = 1'b1; drive(1'b1, 1'b0, 32'd63, 1'b0, '0);
    cfg_abort = 1'b0; idle(1);
    load4(32'd71, 32'd72, 32'd73, 32'd74, 1'b0);
    idle(2);
    // abort while pending
    load4(32'd81, 32'd82, 32'd83, 32'd84, 1'b1);
    cfg_abort = 1'b1; drive(1'b0, 1'b0, '0, 1'b0, '0);
    cfg_abort = 1'b0; idle(2);
`endif

    // enough swaps to wrap coeff_gen
    for (int k = 0; k < 260; k++) begin
      load4($urandom, $urandom, $urandom, $urandom, 1'b0);
      idle(1);
    end

    // random traffic
    for (int k = 0; k < 1500; k++) begin
      rst = ($urandom_range(0, 299) == 0);
`ifdef FIR_CFG_ABORT_EN
      cfg_abort = ($urandom_range(0, 29) == 0);
`endif
      drive($urandom_range(0, 2) != 0,
            (m_words.size() == N - 1) ^ ($urandom_range(0, 9) == 0),
            $urandom, $urandom_range(0, 2) == 0, $urandom);
    end
    rst = 1'b0;
`ifdef FIR_CFG_ABORT_EN
    cfg_abort = 1'b0;
`endif
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_coeff_ctrl.md
Name: fir_coeff_ctrl

Overview:
Coefficient controller and sample sequencer placed in front of the FIR datapaths (pipelined or parallel).
- Accepts a new coefficient set over a serial valid/ready config bus into a shadow bank.
- Swaps shadow and active banks only during a gap in the sample stream, so a filter never sees a partially loaded set.
- Forwards and registers samples, with a one-cycle valid/data stage, to the filter.

Parameters:
N, 100, number of filter taps (bank depth); N >= 2.
COEFF_W, 32, coefficient and sample width (signed Q31).
GEN_W, 8, width of the coefficient-generation counter.

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
cfg_valid  in  1  config word valid
cfg_ready  out  1  controller can accept a config word
cfg_data  in  COEFF_W  coefficient word; word k is written to coeffs[k]
cfg_last  in  1  marks word N-1 of the set
s_valid  in  1  input sample valid
s_data  in  COEFF_W  input sample
f_valid  out  1  valid to the filter
f_x  out  COEFF_W  sample to the filter
coeffs  out  COEFF_W x N  active coefficient bank (unpacked array [N-1:0])
swap_done  out  1  one-cycle pulse: new bank is active from this cycle
load_err  out  1  one-cycle pulse: malformed load discarded
coeff_gen  out  GEN_W  count of successful swaps, wraps modulo 2^GEN_W

Behaviour:
- Reset values:
  - cfg_ready=1, f_valid=0, f_x=0, swap_done=0, load_err=0, coeff_gen=0.
  - Both banks zeroed; bank select sel=0; coeffs all zero; state IDLE.
- Reset mid-load or mid-pending discards everything and returns to these values.
- Sample path:
  - f_valid <= s_valid and f_x <= (s_valid ? s_data : 0), registered.
  - Latency is 1 cycle. There is no backpressure; a sample is taken every cycle s_valid=1.
- Storage:
  - Banks B0 and B1; coeffs = B[sel] combinationally from registered state.
  - The shadow bank is B[~sel]. Writes only ever target the shadow bank.
- Handshake:
  - A word transfers when cfg_valid && cfg_ready.
  - cfg_ready=1 in IDLE and LOAD, 0 in PEND.
- FSM:
  - IDLE:
    - A transfer writes shadow[0] and sets cnt=1.
    - If cfg_last=1 on that word, pulse load_err and stay IDLE (because N>=2). Otherwise go to LOAD.
  - LOAD:
    - A transfer writes shadow[cnt] and increments cnt.
    - If cnt==N-1 and cfg_last=1, go to PEND.
    - If cnt==N-1 and cfg_last=0, pulse load_err and go to IDLE.
    - If cnt<N-1 and cfg_last=1, pulse load_err and go to IDLE.
    - After any error, the shadow contents are don't-care and the active bank is untouched.
  - PEND:
    - In any cycle with s_valid=0: toggle sel, go to IDLE, increment coeff_gen.
    - swap_done pulses in the cycle the new bank appears on coeffs.
    - While s_valid=1, wait indefinitely.
- Boundary and simultaneous events:
  - A swap and a sample never coincide; the first sample after the gap uses the new bank.
  - In IDLE and LOAD, cfg_valid with cfg_ready=1 is always accepted regardless of s_valid.
  - coeff_gen wraps 2^GEN_W-1 -> 0.
  - No words are accepted in PEND; cfg_valid is ignored and the word must be held by the source.

Optional Feature:
FIR_CFG_ABORT_EN.
- Defined:
  - Adds input port cfg_abort (1 bit).
  - cfg_abort=1 in LOAD or PEND returns to IDLE next cycle, with no swap, no load_err and no coeff_gen change.
  - cfg_abort has priority over a simultaneous transfer or swap.
  - In IDLE, cfg_abort is ignored.
- Undefined: the port is absent and the only load exit paths are completion and error.

Decomposition:
- Package fir_pkg contains:
  - localparam COEFF_W.
  - typedef coeff_t (logic signed [COEFF_W-1:0]).
  - typedef enum logic [1:0] cfg_state_t {IDLE, LOAD, PEND}.
- Sub-module fir_coeff_bank holds both banks, sel, the shadow write port (we, addr, data), toggle and the coeffs output.
- Counter, FSM and sample stage stay in the top.

Test Plan:
- Reset and sample path (N=4): assert rst, then stream s_data=5,6,7 with s_valid=1.
  -> coeffs all 0, cfg_ready=1; f_x=5,6,7 one cycle later; f_x=0 when s_valid=0.
- Clean load with an immediate gap (N=4, s_valid=0): send 10,20,30,40 with cfg_last on 40.
  -> swap_done one cycle after the last handshake; coeffs={40,30,20,10} by index; coeff_gen=1.
- Load during a continuous stream: hold s_valid=1 for 20 cycles after the last word, then drop it.
  -> cfg_ready=0 throughout; coeffs unchanged until the first s_valid=0 cycle; then swap_done and the new bank.
- Early cfg_last on word index 1 -> load_err pulse, state IDLE, coeffs and coeff_gen unchanged.
- Missing cfg_last on word index 3 -> same as the early-cfg_last case.
- rst asserted in PEND -> coeffs zero, coeff_gen=0, no swap_done; a subsequent full load succeeds.
- (FIR_CFG_ABORT_EN) cfg_abort after 2 words -> IDLE, no pulse; the next 4-word load swaps with coeff_gen incremented by exactly 1.
